// File: rtl/fifo_pkg.sv
// Shared types and helpers for the stream FIFO family: read-mode selector and
// pointer wrap for depths that need not be a power of two.
package fifo_pkg;

    typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;

    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port with enable.
// The array itself carries no reset.
module fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
        if (re) rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/stream_fifo.sv
// Single-clock valid/ready FIFO with FWFT or standard read mode, arbitrary depth,
// synchronous flush, registered occupancy flags and a high-water mark.
module stream_fifo
    import fifo_pkg::*;
#(
    parameter int         DATA_WIDTH = 8,
    parameter int         DEPTH      = 16,
    parameter int         CNT_WIDTH  = $clog2(DEPTH + 1),
    parameter fifo_mode_e MODE       = FIFO_FWFT,
    parameter int         AE_THRESH  = 4,
    parameter int         AF_THRESH  = DEPTH - 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CNT_WIDTH-1:0]  max_count
);

    localparam int PTR_W = $clog2(DEPTH);

    // Handshake: a beat transfers on an edge where valid and ready are both high.
    // s_ready is a registered function of occupancy (masked only by flush); in STD
    // mode m_ready is a read request and m_valid a one-cycle data pulse.

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d, max_q, max_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  sel_q, sel_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  s_ready_q, s_ready_d;
    logic                  af_q, af_d, ae_q, ae_d;
    logic                  push, pop;
    logic                  ram_re;
    logic [PTR_W-1:0]      ram_raddr;
    logic [DATA_WIDTH-1:0] ram_rdata;

    always_comb begin
        push       = s_valid && s_ready;
        pop        = m_ready && (count_q != '0) && !flush;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        max_d      = max_q;
        data_d     = data_q;
        sel_d      = sel_q;
        rd_valid_d = 1'b0;

        if (push) wr_ptr_d = PTR_W'(ptr_inc(32'(wr_ptr_q), DEPTH));
        if (pop)  rd_ptr_d = PTR_W'(ptr_inc(32'(rd_ptr_q), DEPTH));
        if (push && !pop)      count_d = count_q + CNT_WIDTH'(1);
        else if (pop && !push) count_d = count_q - CNT_WIDTH'(1);

        if (MODE == FIFO_FWFT) begin
            // The RAM cannot show a beat written on this edge, so it is bypassed
            // through data_q whenever that beat becomes the new head.
            if (push && ((count_q == '0) || (pop && count_q == CNT_WIDTH'(1)))) begin
                data_d = s_data;
                sel_d  = 1'b0;
            end else if (count_q != '0) begin
                sel_d = 1'b1;
            end
        end else begin
            rd_valid_d = pop;
            if (pop) sel_d = 1'b1;
        end

        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            data_d     = '0;
            sel_d      = 1'b0;
            rd_valid_d = 1'b0;
            max_d      = '0;
        end else if (count_d > max_q) begin
            max_d = count_d;
        end

        s_ready_d = int'(count_d) < DEPTH;
        af_d      = int'(count_d) >= AF_THRESH;
        ae_d      = int'(count_d) <= AE_THRESH;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            max_q      <= '0;
            data_q     <= '0;
            sel_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            s_ready_q  <= 1'b0;
            af_q       <= (AF_THRESH <= 0);
            ae_q       <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            max_q      <= max_d;
            data_q     <= data_d;
            sel_q      <= sel_d;
            rd_valid_q <= rd_valid_d;
            s_ready_q  <= s_ready_d;
            af_q       <= af_d;
            ae_q       <= ae_d;
        end
    end

    // FWFT prefetches the next head on a pop; STD reads only when serving a request.
    assign ram_re    = (MODE == FIFO_FWFT) ? 1'b1 : pop;
    assign ram_raddr = (MODE == FIFO_FWFT) ? rd_ptr_d : rd_ptr_q;

    fifo_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .ADDR_WIDTH(PTR_W)
    ) u_ram (
        .clk  (clk),
        .we   (push),
        .waddr(wr_ptr_q),
        .wdata(s_data),
        .re   (ram_re),
        .raddr(ram_raddr),
        .rdata(ram_rdata)
    );

    assign s_ready      = s_ready_q && !flush;
    assign m_valid      = (MODE == FIFO_FWFT) ? (count_q != '0) : rd_valid_q;
    assign m_data       = sel_q ? ram_rdata : data_q;
    assign count        = count_q;
    assign max_count    = max_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;

endmodule
